// File: rtl/fa16_pkg.sv
// rtl/fa16_pkg.sv - shared width and word types for the 16-bit ripple adder
package fa16_pkg;
    localparam int W = 16;
    typedef logic [W-1:0] fa16_word_t;
    typedef logic [W:0]   fa16_result_t;
endpackage

// File: rtl/full_adder_16bit_if.sv
// rtl/full_adder_16bit_if.sv - operand/result bundle for full_adder_16bit (ovf under FULL_ADDER_16BIT_OVF_EN)
interface full_adder_16bit_if;
    import fa16_pkg::*;

    fa16_word_t a;
    fa16_word_t b;
    fa16_word_t sum;
    logic       carry;
    fa16_word_t sum_q;
    logic       carry_q;
`ifdef FULL_ADDER_16BIT_OVF_EN
    logic       ovf;
    logic       ovf_q;

    modport master (output a, b, input sum, carry, sum_q, carry_q, ovf, ovf_q);
    modport slave  (input a, b, output sum, carry, sum_q, carry_q, ovf, ovf_q);
`else
    modport master (output a, b, input sum, carry, sum_q, carry_q);
    modport slave  (input a, b, output sum, carry, sum_q, carry_q);
`endif
endinterface

// File: rtl/full_adder_1b.sv
// rtl/full_adder_1b.sv - single-bit full adder cell for the ripple chain
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/full_adder_16bit.sv
// rtl/full_adder_16bit.sv - 16-bit ripple-carry adder with registered copy; FULL_ADDER_16BIT_OVF_EN adds signed overflow
module full_adder_16bit
    import fa16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    full_adder_16bit_if.slave bus
);
    logic [W:0]   c;
    fa16_word_t   s;
    fa16_result_t res_d;
    fa16_result_t res_q;

    // No carry-in: the chain starts at zero
    assign c[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_bit
            full_adder_1b u_fa (
                .a    (bus.a[i]),
                .b    (bus.b[i]),
                .cin  (c[i]),
                .s    (s[i]),
                .cout (c[i+1])
            );
        end
    endgenerate

    assign bus.sum   = s;
    assign bus.carry = c[W];

    always_comb begin
        res_d = {c[W], s};
    end

`ifdef FULL_ADDER_16BIT_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow: like-signed operands produced an opposite-signed sum
    always_comb begin
        ovf_d = (bus.a[W-1] == bus.b[W-1]) && (s[W-1] != bus.a[W-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            res_q <= res_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf   = ovf_d;
    assign bus.ovf_q = ovf_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end
`endif

    assign bus.sum_q   = res_q[W-1:0];
    assign bus.carry_q = res_q[W];
endmodule

// File: tb/tb_full_adder_16bit.sv
// tb/tb_full_adder_16bit.sv - randomized self-checking bench for full_adder_16bit
module tb_full_adder_16bit;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    full_adder_16bit_if bus ();

    full_adder_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y);
        int unsigned t;
        t = int'(x) + int'(y);
        return t[16:0];
    endfunction

    function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y);
        int t;
        t = int'($signed(x)) + int'($signed(y));
        return (t > 32767) || (t < -32768);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.a = 16'h0000;
        bus.b = 16'h0000;
        #5;
        n_cmp++;
        if ({bus.carry, bus.sum} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_comb got=%h exp=%h", {bus.carry, bus.sum}, 17'h0);
        end
        n_cmp++;
        if ({bus.carry_q, bus.sum_q} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_reg got=%h exp=%h", {bus.carry_q, bus.sum_q}, 17'h0);
        end
`ifdef FULL_ADDER_16BIT_OVF_EN
        n_cmp++;
        if ({bus.ovf, bus.ovf_q} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ovf got=%b exp=00", {bus.ovf, bus.ovf_q});
        end
`endif
    endtask

    task automatic test_corners();
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic [16:0] exp;
        va = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h5555};
        vb = '{16'h0000, 16'hFFFF, 16'h0001, 16'h0001, 16'h8000, 16'hAAAA};
        for (int k = 0; k < 6; k++) begin
            bus.a = va[k];
            bus.b = vb[k];
            #5;
            exp = ref_add(va[k], vb[k]);
            n_cmp++;
            if ({bus.carry, bus.sum} !== exp) begin
                n_err++;
                $display("FAIL corner[%0d] a=%h b=%h got=%h exp=%h", k, va[k], vb[k], {bus.carry, bus.sum}, exp);
            end
`ifdef FULL_ADDER_16BIT_OVF_EN
            n_cmp++;
            if (bus.ovf !== ref_ovf(va[k], vb[k])) begin
                n_err++;
                $display("FAIL corner_ovf[%0d] got=%b exp=%b", k, bus.ovf, ref_ovf(va[k], vb[k]));
            end
`endif
        end
    endtask

    task automatic test_random();
        logic [15:0] x;
        logic [15:0] y;
        logic [16:0] exp;
        for (int k = 0; k < 1000; k++) begin
            x = 16'($urandom_range(0, 65535));
            y = 16'($urandom_range(0, 65535));
            bus.a = x;
            bus.b = y;
            #5;
            exp = ref_add(x, y);
            n_cmp++;
            if ({bus.carry, bus.sum} !== exp) begin
                n_err++;
                $display("FAIL rand[%0d] a=%h b=%h got=%h exp=%h", k, x, y, {bus.carry, bus.sum}, exp);
                break;
            end
`ifdef FULL_ADDER_16BIT_OVF_EN
            n_cmp++;
            if (bus.ovf !== ref_ovf(x, y)) begin
                n_err++;
                $display("FAIL rand_ovf[%0d] a=%h b=%h got=%b exp=%b", k, x, y, bus.ovf, ref_ovf(x, y));
                break;
            end
`endif
        end
    endtask

    task automatic test_reset_hold();
        @(negedge clk);
        rst_n = 1'b0;
        bus.a = 16'h1234;
        bus.b = 16'h1111;
        #5;
        n_cmp++;
        if (bus.sum !== 16'h2345) begin
            n_err++;
            $display("FAIL hold_comb got=%h exp=2345", bus.sum);
        end
        n_cmp++;
        if (bus.sum_q !== 16'h0000) begin
            n_err++;
            $display("FAIL hold_reg got=%h exp=0000", bus.sum_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.carry_q, bus.sum_q} !== 17'h02345) begin
            n_err++;
            $display("FAIL release_reg got=%h exp=02345", {bus.carry_q, bus.sum_q});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] x;
        logic [15:0] y;
        logic [16:0] exp;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            x = 16'($urandom);
            y = 16'($urandom);
            if (k == 0) begin
                x = 16'hFFFF;
                y = 16'hFFFF;
            end
            bus.a = x;
            bus.b = y;
            exp = ref_add(x, y);
            @(posedge clk);
            #1;
            // Change inputs right after the edge: the register must hold
            bus.a = ~x;
            n_cmp++;
            if ({bus.carry_q, bus.sum_q} !== exp) begin
                n_err++;
                $display("FAIL b2b[%0d] a=%h b=%h got=%h exp=%h", k, x, y, {bus.carry_q, bus.sum_q}, exp);
            end
`ifdef FULL_ADDER_16BIT_OVF_EN
            n_cmp++;
            if (bus.ovf_q !== ref_ovf(x, y)) begin
                n_err++;
                $display("FAIL b2b_ovf[%0d] got=%b exp=%b", k, bus.ovf_q, ref_ovf(x, y));
            end
`endif
        end
    endtask

    task automatic test_midstream_reset();
        @(negedge clk);
        bus.a = 16'hF00F;
        bus.b = 16'h1FF1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.carry_q, bus.sum_q} !== ref_add(16'hF00F, 16'h1FF1)) begin
            n_err++;
            $display("FAIL pre_reset got=%h exp=%h", {bus.carry_q, bus.sum_q}, ref_add(16'hF00F, 16'h1FF1));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.carry_q, bus.sum_q} !== 17'h0) begin
            n_err++;
            $display("FAIL async_reset got=%h exp=00000", {bus.carry_q, bus.sum_q});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.carry_q, bus.sum_q} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_held got=%h exp=00000", {bus.carry_q, bus.sum_q});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.a = '0;
        bus.b = '0;
        test_reset();
        test_corners();
        test_random();
        test_reset_hold();
        test_back_to_back();
        test_midstream_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
